// File: rtl/thresholding_pkg.sv
// Shared helpers for the multi-threshold unit.
// idx2stage/idx2slot map a flat ascending threshold index onto the binary
// search tree. The middle threshold is the root (stage 0), and the outermost
// thresholds are the leaves (stage N-1). params_ok gives the legal parameter set.
package thresholding_pkg;

  function automatic int trailing_ones(input int i, input int n);
    int  t;
    bit  run;
    t   = 0;
    run = 1'b1;
    for (int b = 0; b < n; b++) begin
      if (run && ((i >> b) & 1) == 1) t++;
      else run = 1'b0;
    end
    return t;
  endfunction

  function automatic int idx2stage(input int i, input int n);
    return n - 1 - trailing_ones(i, n);
  endfunction

  function automatic int idx2slot(input int i, input int n);
    return i >> (trailing_ones(i, n) + 1);
  endfunction

  function automatic bit params_ok(input int c, input int pe, input int n, input int o_bits);
    return (pe > 0) && (c % pe == 0) && (o_bits >= n);
  endfunction

endpackage

// File: rtl/thresholding_stage.sv
// One binary-search stage of one lane.
// The stage memory holds CF*2^S thresholds. Word address = {channel, slot}.
// The prefix bits found so far are the slot into this stage. Each stage
// registers the incoming beat and reads its threshold in the same cycle. It
// then compares that threshold and appends one count bit, LSB-side, on its output.
// Ports: clk, rst_n, en_i (global advance), vld_i/x_i/ch_i/pre_i (beat in),
//        vld_o/x_o/ch_o/pre_o (beat out, pre_o includes this stage's bit),
//        cfg_we_i/cfg_ch_i/cfg_slot_i/cfg_d_i (pre-decoded write),
//        cfg_rd_o (combinational readback of the configured word).
module thresholding_stage
  import thresholding_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 8,
  parameter int CF     = 2,
  parameter int S      = 0,
  parameter int SIGNED = 1,
  parameter int CHW    = (CF > 1) ? $clog2(CF) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           vld_i,
  input  logic [M-1:0]   x_i,
  input  logic [CHW-1:0] ch_i,
  input  logic [N-1:0]   pre_i,
  output logic           vld_o,
  output logic [M-1:0]   x_o,
  output logic [CHW-1:0] ch_o,
  output logic [N-1:0]   pre_o,
  input  logic           cfg_we_i,
  input  logic [CHW-1:0] cfg_ch_i,
  input  logic [N-1:0]   cfg_slot_i,
  input  logic [M-1:0]   cfg_d_i,
  output logic [M-1:0]   cfg_rd_o
);
  localparam int DEPTH = CF << S;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [M-1:0]   mem_q [DEPTH];
  logic           vld_q;
  logic [M-1:0]   x_q;
  logic [M-1:0]   t_q;
  logic [CHW-1:0] ch_q;
  logic [N-1:0]   pre_q;
  logic [AW-1:0]  rd_a;
  logic [AW-1:0]  cfg_wa;

  function automatic logic thr_le(input logic [M-1:0] t, input logic [M-1:0] x);
    if (SIGNED != 0) return $signed(t) <= $signed(x);
    return t <= x;
  endfunction

  // Only the low S prefix bits select a slot; the root stage has a single slot.
  function automatic logic [AW-1:0] word_addr(input logic [CHW-1:0] ch, input logic [N-1:0] slot);
    logic [31:0] lo;
    lo = 32'(slot) & ((32'd1 << S) - 32'd1);
    return AW'((32'(ch) << S) | lo);
  endfunction

  assign rd_a   = word_addr(ch_i, pre_i);
  assign cfg_wa = word_addr(cfg_ch_i, cfg_slot_i);

  always_ff @(posedge clk) begin
    if (cfg_we_i) mem_q[cfg_wa] <= cfg_d_i;
  end

  // ---- stage register: beat capture + threshold read ----
  always_ff @(posedge clk) begin
    if (!rst_n)    vld_q <= 1'b0;
    else if (en_i) vld_q <= vld_i;
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      x_q   <= x_i;
      ch_q  <= ch_i;
      pre_q <= pre_i;
      t_q   <= mem_q[rd_a];
    end
  end

  // ---- compare: append this stage's count bit ----
  assign vld_o    = vld_q;
  assign x_o      = x_q;
  assign ch_o     = ch_q;
  assign pre_o    = N'({pre_q, thr_le(t_q, x_q)});
  assign cfg_rd_o = mem_q[cfg_wa];

endmodule

// File: rtl/thresholding_axis_pe.sv
// PE-lane multi-threshold unit. y = number of ascending thresholds T_i <= x.
// This is found by an N-stage pipelined binary search plus one output register.
// Channels are folded by a shared counter: lane p at counter c is channel c*PE+p.
// Stream interface is AXI-Stream with full backpressure through one global
// enable. Thresholds are written and read back through a flat
// {lane, channel, index} address.
// Ports: clk, rst_n (sync, active-low); cfg_we/cfg_re/cfg_a/cfg_d write and
//        read strobes; cfg_rvld/cfg_rdata readback one cycle after cfg_re;
//        s_tvalid/s_tready/s_tdata input stream, lane p at [p*M+:M];
//        m_tvalid/m_tready/m_tdata output stream, lane p at [p*O_BITS+:O_BITS].
module thresholding_axis_pe
  import thresholding_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 8,
  parameter int C      = 4,
  parameter int PE     = 2,
  parameter int SIGNED = 1,
  parameter int BIAS   = 0,
  parameter int O_BITS = N
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic                               cfg_re,
  input  logic [$clog2(PE)+$clog2(C/PE)+N-1:0] cfg_a,
  input  logic [M-1:0]                       cfg_d,
  output logic                               cfg_rvld,
  output logic [M-1:0]                       cfg_rdata,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic [PE*M-1:0]                    s_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [PE*O_BITS-1:0]               m_tdata
);
  localparam int CF  = C / PE;
  localparam int CFW = $clog2(CF);
  localparam int CHW = (CF > 1) ? CFW : 1;
  localparam int LW  = (PE > 1) ? $clog2(PE) : 1;

  if (!params_ok(C, PE, N, O_BITS)) begin : g_param_err
    $error("thresholding_axis_pe: C must be a multiple of PE and O_BITS must be >= N");
  end

  logic                 en;
  logic [CHW-1:0]       cnt_q, cnt_d;
  logic                 m_vld_q;
  logic [PE*O_BITS-1:0] m_data_q, m_data_d;
  logic                 rvld_q;
  logic [M-1:0]         rdata_q;
  logic [M-1:0]         rd_sel;

  logic [N-1:0]   cfg_idx;
  logic [CHW-1:0] cfg_ch;
  logic [LW-1:0]  cfg_lane;
  logic           cfg_idx_ok;
  logic           cfg_lane_ok;
  int             cfg_stage;
  int             cfg_slot;

  logic           vld_w [PE][N];
  logic [M-1:0]   x_w   [PE][N];
  logic [CHW-1:0] ch_w  [PE][N];
  logic [N-1:0]   pre_w [PE][N];
  logic [M-1:0]   rd_w  [PE][N];

  function automatic logic [O_BITS-1:0] add_bias(input logic [N-1:0] cnt);
    return O_BITS'(cnt) + O_BITS'(BIAS);
  endfunction

  assign en       = !m_vld_q || m_tready;
  assign s_tready = en;

  // Address fields may be zero-width (CF=1 or PE=1), so they are extracted by shift.
  always_comb begin
    cfg_idx     = cfg_a[N-1:0];
    cfg_ch      = '0;
    cfg_lane    = '0;
    if (CF > 1) cfg_ch = CHW'(cfg_a >> N);
    if (PE > 1) cfg_lane = LW'(cfg_a >> (N + CFW));
    cfg_idx_ok  = (cfg_idx != '1);
    cfg_lane_ok = (int'(cfg_lane) < PE);
    cfg_stage   = 0;
    cfg_slot    = 0;
    if (cfg_idx_ok) begin
      cfg_stage = idx2stage(int'(cfg_idx), N);
      cfg_slot  = idx2slot(int'(cfg_idx), N);
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int p = 0; p < PE; p++)
      for (int s = 0; s < N; s++)
        if (p == int'(cfg_lane) && s == cfg_stage) rd_sel = rd_w[p][s];
  end

  for (genvar p = 0; p < PE; p++) begin : g_lane
    for (genvar s = 0; s < N; s++) begin : g_stage
      logic           vld_in;
      logic [M-1:0]   x_in;
      logic [CHW-1:0] ch_in;
      logic [N-1:0]   pre_in;

      if (s == 0) begin : g_first
        assign vld_in = s_tvalid;
        assign x_in   = s_tdata[p*M +: M];
        assign ch_in  = cnt_q;
        assign pre_in = '0;
      end else begin : g_next
        assign vld_in = vld_w[p][s-1];
        assign x_in   = x_w[p][s-1];
        assign ch_in  = ch_w[p][s-1];
        assign pre_in = pre_w[p][s-1];
      end

      thresholding_stage #(
        .N(N), .M(M), .CF(CF), .S(s), .SIGNED(SIGNED), .CHW(CHW)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .vld_i     (vld_in),
        .x_i       (x_in),
        .ch_i      (ch_in),
        .pre_i     (pre_in),
        .vld_o     (vld_w[p][s]),
        .x_o       (x_w[p][s]),
        .ch_o      (ch_w[p][s]),
        .pre_o     (pre_w[p][s]),
        .cfg_we_i  (cfg_we && cfg_idx_ok && (cfg_lane == LW'(p)) && (cfg_stage == s)),
        .cfg_ch_i  (cfg_ch),
        .cfg_slot_i(N'(cfg_slot)),
        .cfg_d_i   (cfg_d),
        .cfg_rd_o  (rd_w[p][s])
      );
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s_tvalid && en) cnt_d = (int'(cnt_q) == CF - 1) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    m_data_d = '0;
    for (int p = 0; p < PE; p++) m_data_d[p*O_BITS +: O_BITS] = add_bias(pre_w[p][N-1]);
  end

  // ---- output register + control state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      m_vld_q <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rvld_q <= cfg_re && !cfg_we && cfg_idx_ok && cfg_lane_ok;
      if (en) m_vld_q <= vld_w[0][N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en)     m_data_q <= m_data_d;
    if (cfg_re) rdata_q  <= rd_sel;
  end

  assign m_tvalid  = m_vld_q;
  assign m_tdata   = m_data_q;
  assign cfg_rvld  = rvld_q;
  assign cfg_rdata = rdata_q;

endmodule

// File: doc/thresholding_axis_pe.md
Name: thresholding_axis_pe

Overview:
- Next-generation multi-threshold unit: y = Σ(T_i <= x) over 2^N-1 ascending thresholds, computed by pipelined binary search.
- Generalised to PE parallel lanes, with channel folding driven by an internal channel counter.
- AXI-Stream ready/valid with full backpressure, flat-index threshold writes, and a threshold readback port.
- Sits between the MVAU output stream and the next layer's input stream.

Parameters:
- N, 4: output precision; thresholds per channel = 2^N-1.
- M, 8: input/threshold width.
- C, 4: total channels; must be divisible by PE.
- PE, 2: parallel lanes; CF = C/PE channels folded per lane.
- SIGNED, 1: signed compare of inputs and thresholds.
- BIAS, 0: signed offset added to the count.
- O_BITS, N: output width per lane; must be >= N.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset.
- cfg_we, in, 1: threshold write strobe.
- cfg_re, in, 1: threshold read strobe.
- cfg_a, in, $clog2(PE)+$clog2(CF)+N: address {lane, channel, index}.
- cfg_d, in, M: write data.
- cfg_rvld, out, 1: readback valid.
- cfg_rdata, out, M: readback data.
- s_tvalid, in, 1: input stream valid.
- s_tready, out, 1: input stream ready.
- s_tdata, in, PE*M: input stream; lane p at bits [p*M+:M].
- m_tvalid, out, 1: output stream valid.
- m_tready, in, 1: output stream ready.
- m_tdata, out, PE*O_BITS: output stream; lane p at bits [p*O_BITS+:O_BITS].

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - While rst_n=0 at a clk edge: m_tvalid=0, cfg_rvld=0, all stage valids=0, channel counter=0.
  - Thresholds are not reset and survive reset.
  - Beats in flight when reset is asserted are discarded; m_tvalid is 0 on the first cycle after the reset edge.
- Threshold addressing:
  - Index i ∈ [0, 2^N-2] in ascending order.
  - t = count of trailing ones of i; stage s = N-1-t; slot within the stage = i >> (t+1).
  - Index 2^N-1 (all ones) is ignored on both write and read.
- Memory per lane per stage: CF*2^s words.
  - Written when cfg_we is high and the lane field matches.
  - Write is visible to stream reads issued on the next cycle.
  - No hazard protection for writes during streaming.
- Readback:
  - cfg_re without cfg_we gives cfg_rvld=1 exactly one cycle later, with cfg_rdata holding the addressed word.
  - cfg_re together with cfg_we: the write wins and cfg_rvld stays 0.
- Pipeline:
  - N+1 stages: N search stages, each with one registered threshold read and one compare, followed by one output register.
  - Latency from input handshake to m_tvalid is N+1 cycles when the output is not stalled.
- Global enable en = !m_tvalid || m_tready.
  - s_tready = en (combinational from m_tready).
  - When en=0 every stage holds: m_tdata stable, no loss, no duplication.
  - Bubbles propagate; they are not compacted.
- Channel counter:
  - Increments on each s_tvalid&&s_tready.
  - Wraps CF-1 -> 0.
  - Is shared by all lanes; lane p / counter c processes channel c*PE+p.
- Compare: T <= x, signed when SIGNED=1, otherwise unsigned. Count bits are assembled MSB-first.
- Output: m_tdata lane = zero-extended count + BIAS, truncated modulo 2^O_BITS (two's complement).
- With CF=1 the channel field of cfg_a has width 0; with PE=1 the lane field has width 0.

Decomposition:
- Package thresholding_pkg holds:
  - Function idx2stage(i, N).
  - Function idx2slot(i, N).
  - Parameter-checking assertions: C%PE==0, O_BITS>=N.
- One sub-module, thresholding_stage.
  - Contains one lane's stage memory, read register, compare and state register.
  - Generated N×PE times.

Test Plan:
- Basic unsigned search (N=2, M=8, C=1, PE=1, SIGNED=0).
  - Stimulus: write T = 10, 20, 30 at indices 0..2; stream 5, 10, 25, 30, 255.
  - Required: m_tdata 0, 1, 2, 3, 3; first output 3 cycles after the input handshake.
- Signed with bias (SIGNED=1, BIAS=-2, O_BITS=4).
  - Stimulus: T = -4, 0, 4; stream -128, -4, 3, 127.
  - Required: m_tdata 0xE, 0xF, 0x0, 0x1.
- Folding (C=4, PE=2, N=2).
  - Stimulus: channel k thresholds = 10k+1, 10k+2, 10k+3; stream 8 beats, each lane input = 10k+2 for its channel.
  - Required: every output = 2, proving the channel counter wraps 1 -> 0 correctly.
- Backpressure.
  - Stimulus: continuous input; hold m_tready=0 for 5 cycles mid-stream.
  - Required: s_tready=0 during the stall, m_tdata unchanged, output sequence equal to the unstalled reference, no drops or duplicates.
- Reset mid-stream.
  - Stimulus: rst_n=0 for one cycle with 3 beats in flight.
  - Required: m_tvalid=0 next cycle, channel counter=0, old thresholds still give correct results afterwards.
- Readback and collision.
  - Stimulus: cfg_re at index 1 returns 20 with cfg_rvld one cycle later; then cfg_we+cfg_re on the same cycle.
  - Required: cfg_rvld stays 0 for the collision, and the new value reads back on the next cfg_re.
